// File: rtl/seg_text_scroller.sv
// Scrolls "ALMATY" or "ASTANA" across six 7-segment digits (hex5 leftmost).
// Two raw active-low buttons are synchronised and debounced here: one toggles
// the message, the other toggles run/pause. All outputs are registered.
module seg_text_scroller #(
    parameter int STEP_CYCLES     = 12500000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SEG_ACTIVE_LOW  = 1
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       key_sel_n,
    input  logic       key_run_n,
    output logic [6:0] hex5,
    output logic [6:0] hex4,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       msg_sel,
    output logic       running,
    output logic [3:0] pos
);

    localparam int PS_W = $clog2(STEP_CYCLES);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} state_t;

    // Button index 0 = select, 1 = run/pause.
    logic [1:0]      key_raw;
    logic [1:0]      key_sync_p0;
    logic [1:0]      key_sync_p1;
    logic [1:0]      db_level;
    logic [1:0]      db_prev;
    logic [1:0]      armed;
    logic [1:0]      settle;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press;
    logic            sel_press;
    logic            run_press;

    state_t          state;
    logic [PS_W-1:0] presc;

    assign key_raw = {key_run_n, key_sel_n};

    // Active-high glyph for a character slot of a message, polarity applied.
    function automatic logic [6:0] glyph(input logic msg, input logic [3:0] idx);
        logic [6:0] g;
        g = 7'b0000000;
        if (!msg) begin
            case (idx)
                4'd0:    g = 7'b1110111; // A
                4'd1:    g = 7'b0111000; // L
                4'd2:    g = 7'b0110111; // M
                4'd3:    g = 7'b1110111; // A
                4'd4:    g = 7'b1111000; // T
                4'd5:    g = 7'b1101110; // Y
                default: g = 7'b0000000;
            endcase
        end else begin
            case (idx)
                4'd0:    g = 7'b1110111; // A
                4'd1:    g = 7'b1101101; // S
                4'd2:    g = 7'b1111000; // T
                4'd3:    g = 7'b1110111; // A
                4'd4:    g = 7'b1010100; // N
                4'd5:    g = 7'b1110111; // A
                default: g = 7'b0000000;
            endcase
        end
        return (SEG_ACTIVE_LOW != 0) ? ~g : g;
    endfunction

    // Glyph for digit k of the window starting at base, wrapping modulo 12.
    function automatic logic [6:0] window(input logic msg, input logic [3:0] base,
                                          input logic [2:0] k);
        logic [4:0] sum;
        sum = {1'b0, base} + {2'b00, k};
        return glyph(msg, (sum > 5'd11) ? 4'(sum - 5'd12) : sum[3:0]);
    endfunction

    // A press is a debounced 1-to-0 edge, suppressed until the button has been
    // seen released since reset so a key held through reset stays silent.
    assign press     = db_prev & ~db_level & armed;
    assign sel_press = press[0];
    assign run_press = press[1];

    // Synchronise, debounce and arm both buttons.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            key_sync_p0 <= 2'b11;
            key_sync_p1 <= 2'b11;
            db_level    <= 2'b11;
            db_prev     <= 2'b11;
            armed       <= 2'b00;
            settle      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            key_sync_p0 <= key_raw;
            key_sync_p1 <= key_sync_p0;
            db_prev     <= db_level;
            // settle reaches 2 once key_sync_p1 holds a real sample, not a reset value
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end
            for (int i = 0; i < 2; i++) begin
                if (key_sync_p1[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= key_sync_p1[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
                if (settle == 2'd2 && key_sync_p1[i] && db_level[i]) begin
                    armed[i] <= 1'b1;
                end
            end
        end
    end

    // Run/pause state machine, prescaler, scroll position and message select.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state   <= RUN;
            running <= 1'b1;
            msg_sel <= 1'b0;
            pos     <= 4'd0;
            presc   <= '0;
        end else begin
            // Select restarts the scroll and overrides a coincident step.
            if (sel_press) begin
                msg_sel <= ~msg_sel;
                pos     <= 4'd0;
                presc   <= '0;
            end else if (state == RUN) begin
                if (presc == PS_LAST) begin
                    presc <= '0;
                    pos   <= (pos == 4'd11) ? 4'd0 : pos + 4'd1;
                end else begin
                    presc <= presc + PS_W'(1);
                end
            end
            if (run_press) begin
                state   <= (state == RUN) ? PAUSE : RUN;
                running <= (state != RUN);
            end
        end
    end

    // Display stage: segment patterns registered from the current msg_sel/pos.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            hex5 <= window(1'b0, 4'd0, 3'd0);
            hex4 <= window(1'b0, 4'd0, 3'd1);
            hex3 <= window(1'b0, 4'd0, 3'd2);
            hex2 <= window(1'b0, 4'd0, 3'd3);
            hex1 <= window(1'b0, 4'd0, 3'd4);
            hex0 <= window(1'b0, 4'd0, 3'd5);
        end else begin
            hex5 <= window(msg_sel, pos, 3'd0);
            hex4 <= window(msg_sel, pos, 3'd1);
            hex3 <= window(msg_sel, pos, 3'd2);
            hex2 <= window(msg_sel, pos, 3'd3);
            hex1 <= window(msg_sel, pos, 3'd4);
            hex0 <= window(msg_sel, pos, 3'd5);
        end
    end

endmodule

// File: tb/tb_seg_text_scroller.sv
// Directed bench for seg_text_scroller with STEP_CYCLES=4, DEBOUNCE_CYCLES=3,
// active-low segments. Tasks run in sequence; each starts from the state the
// previous one left behind. Inputs are driven and outputs sampled 1 ns after
// the rising edge.
module tb_seg_text_scroller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_sel_n;
    logic       key_run_n;
    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic       msg_sel;
    logic       running;
    logic [3:0] pos;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GL = 7'b1000111;
    localparam logic [6:0] GM = 7'b1001000;
    localparam logic [6:0] GN = 7'b0101011;
    localparam logic [6:0] GS = 7'b0010010;
    localparam logic [6:0] GT = 7'b0000111;
    localparam logic [6:0] GY = 7'b0010001;
    localparam logic [6:0] GB = 7'b1111111;

    logic [6:0] got [6];
    logic [6:0] exp [6];

    seg_text_scroller #(
        .STEP_CYCLES    (4),
        .DEBOUNCE_CYCLES(3),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .key_sel_n(key_sel_n),
        .key_run_n(key_run_n),
        .hex5     (hex5),
        .hex4     (hex4),
        .hex3     (hex3),
        .hex2     (hex2),
        .hex1     (hex1),
        .hex0     (hex0),
        .msg_sel  (msg_sel),
        .running  (running),
        .pos      (pos)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        key_sel_n = 1'b1;
        key_run_n = 1'b1;
        cyc(1);
        got = '{hex5, hex4, hex3, hex2, hex1, hex0};
        exp = '{GA, GL, GM, GA, GT, GY};
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
                failures++;
                $display("FAIL reset_hex%0d got=%b exp=%b", 5 - k, got[k], exp[k]);
            end
        end
        checks++;
        if (msg_sel !== 1'b0) begin failures++; $display("FAIL reset_msg_sel got=%b exp=0", msg_sel); end
        checks++;
        if (running !== 1'b1) begin failures++; $display("FAIL reset_running got=%b exp=1", running); end
        checks++;
        if (pos !== 4'd0) begin failures++; $display("FAIL reset_pos got=%0d exp=0", pos); end
        rst_n = 1'b1;
    endtask

    task automatic test_free_run;
        for (int i = 1; i <= 48; i++) begin
            cyc(1);
            if (i % 4 == 0) begin
                checks++;
                if (pos !== 4'((i / 4) % 12)) begin
                    failures++;
                    $display("FAIL free_run_pos edge=%0d got=%0d exp=%0d", i, pos, (i / 4) % 12);
                end
            end
            if (i == 25) begin
                got = '{hex5, hex4, hex3, hex2, hex1, hex0};
                for (int k = 0; k < 6; k++) begin
                    checks++;
                    if (got[k] !== GB) begin
                        failures++;
                        $display("FAIL blank_hex%0d got=%b exp=%b", 5 - k, got[k], GB);
                    end
                end
            end
            if (i == 45) begin
                got = '{hex5, hex4, hex3, hex2, hex1, hex0};
                exp = '{GB, GA, GL, GM, GA, GT};
                for (int k = 0; k < 6; k++) begin
                    checks++;
                    if (got[k] !== exp[k]) begin
                        failures++;
                        $display("FAIL pos11_hex%0d got=%b exp=%b", 5 - k, got[k], exp[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_glitch;
        key_sel_n = 1'b0;
        cyc(2);
        key_sel_n = 1'b1;
        cyc(8);
        checks++;
        if (msg_sel !== 1'b0) begin failures++; $display("FAIL glitch_msg_sel got=%b exp=0", msg_sel); end
    endtask

    task automatic test_sel_hold;
        key_sel_n = 1'b0;
        cyc(5);
        checks++;
        if (msg_sel !== 1'b0) begin failures++; $display("FAIL sel_early got=%b exp=0", msg_sel); end
        cyc(1);
        checks++;
        if (msg_sel !== 1'b1) begin failures++; $display("FAIL sel_toggle got=%b exp=1", msg_sel); end
        checks++;
        if (pos !== 4'd0) begin failures++; $display("FAIL sel_pos got=%0d exp=0", pos); end
        cyc(1);
        got = '{hex5, hex4, hex3, hex2, hex1, hex0};
        exp = '{GA, GS, GT, GA, GN, GA};
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
                failures++;
                $display("FAIL astana_hex%0d got=%b exp=%b", 5 - k, got[k], exp[k]);
            end
        end
        cyc(3);
        key_sel_n = 1'b1;
        cyc(6);
        checks++;
        if (msg_sel !== 1'b1) begin failures++; $display("FAIL sel_release got=%b exp=1", msg_sel); end
        checks++;
        if (pos !== 4'd2) begin failures++; $display("FAIL sel_after_pos got=%0d exp=2", pos); end
    endtask

    task automatic test_run_pause;
        // pos=2, prescaler=2 on entry
        key_run_n = 1'b0;
        cyc(5);
        checks++;
        if (running !== 1'b1) begin failures++; $display("FAIL pause_early_running got=%b exp=1", running); end
        checks++;
        if (pos !== 4'd3) begin failures++; $display("FAIL pause_early_pos got=%0d exp=3", pos); end
        cyc(1);
        checks++;
        if (running !== 1'b0) begin failures++; $display("FAIL pause_running got=%b exp=0", running); end
        checks++;
        if (pos !== 4'd4) begin failures++; $display("FAIL pause_step_pos got=%0d exp=4", pos); end
        cyc(2);
        key_run_n = 1'b1;
        cyc(98);
        checks++;
        if (pos !== 4'd4) begin failures++; $display("FAIL paused_pos got=%0d exp=4", pos); end
        checks++;
        if (running !== 1'b0) begin failures++; $display("FAIL paused_running got=%b exp=0", running); end
        key_run_n = 1'b0;
        cyc(6);
        checks++;
        if (running !== 1'b1) begin failures++; $display("FAIL resume_running got=%b exp=1", running); end
        cyc(2);
        key_run_n = 1'b1;
        cyc(1);
        checks++;
        if (pos !== 4'd4) begin failures++; $display("FAIL resume_hold_pos got=%0d exp=4", pos); end
        cyc(1);
        checks++;
        if (pos !== 4'd5) begin failures++; $display("FAIL resume_step_pos got=%0d exp=5", pos); end
        cyc(6);
    endtask

    task automatic test_back_to_back;
        // RUN, msg 1, pos=6, prescaler=2 on entry
        key_sel_n = 1'b0;
        key_run_n = 1'b0;
        cyc(5);
        checks++;
        if (pos !== 4'd7) begin failures++; $display("FAIL both_pre_pos got=%0d exp=7", pos); end
        checks++;
        if (msg_sel !== 1'b1) begin failures++; $display("FAIL both_pre_msg got=%b exp=1", msg_sel); end
        cyc(1);
        checks++;
        if (pos !== 4'd0) begin failures++; $display("FAIL both_pos got=%0d exp=0", pos); end
        checks++;
        if (msg_sel !== 1'b0) begin failures++; $display("FAIL both_msg got=%b exp=0", msg_sel); end
        checks++;
        if (running !== 1'b0) begin failures++; $display("FAIL both_running got=%b exp=0", running); end
        cyc(2);
        key_sel_n = 1'b1;
        key_run_n = 1'b1;
        cyc(6);
    endtask

    task automatic test_pause_at_seven;
        key_sel_n = 1'b0;
        cyc(6);
        checks++;
        if (msg_sel !== 1'b1) begin failures++; $display("FAIL pause_sel_msg got=%b exp=1", msg_sel); end
        checks++;
        if (running !== 1'b0) begin failures++; $display("FAIL pause_sel_running got=%b exp=0", running); end
        cyc(2);
        key_sel_n = 1'b1;
        cyc(6);
        key_run_n = 1'b0;
        cyc(6);
        checks++;
        if (running !== 1'b1) begin failures++; $display("FAIL rerun_running got=%b exp=1", running); end
        cyc(2);
        key_run_n = 1'b1;
        cyc(21);
        key_run_n = 1'b0;
        cyc(6);
        checks++;
        if (running !== 1'b0) begin failures++; $display("FAIL p7_running got=%b exp=0", running); end
        checks++;
        if (pos !== 4'd7) begin failures++; $display("FAIL p7_pos got=%0d exp=7", pos); end
        cyc(2);
        key_run_n = 1'b1;
        cyc(7);
        checks++;
        if (pos !== 4'd7) begin failures++; $display("FAIL p7_hold_pos got=%0d exp=7", pos); end
        got = '{hex5, hex4, hex3, hex2, hex1, hex0};
        exp = '{GB, GB, GB, GB, GB, GA};
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
                failures++;
                $display("FAIL p7_hex%0d got=%b exp=%b", 5 - k, got[k], exp[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        key_sel_n = 1'b0;
        rst_n = 1'b0;
        cyc(1);
        got = '{hex5, hex4, hex3, hex2, hex1, hex0};
        exp = '{GA, GL, GM, GA, GT, GY};
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
                failures++;
                $display("FAIL midrst_hex%0d got=%b exp=%b", 5 - k, got[k], exp[k]);
            end
        end
        checks++;
        if (msg_sel !== 1'b0) begin failures++; $display("FAIL midrst_msg got=%b exp=0", msg_sel); end
        checks++;
        if (running !== 1'b1) begin failures++; $display("FAIL midrst_running got=%b exp=1", running); end
        checks++;
        if (pos !== 4'd0) begin failures++; $display("FAIL midrst_pos got=%0d exp=0", pos); end
        rst_n = 1'b1;
        cyc(20);
        checks++;
        if (msg_sel !== 1'b0) begin failures++; $display("FAIL held_key_msg got=%b exp=0", msg_sel); end
        key_sel_n = 1'b1;
        cyc(10);
        key_sel_n = 1'b0;
        cyc(5);
        checks++;
        if (msg_sel !== 1'b0) begin failures++; $display("FAIL repress_early got=%b exp=0", msg_sel); end
        cyc(1);
        checks++;
        if (msg_sel !== 1'b1) begin failures++; $display("FAIL repress_msg got=%b exp=1", msg_sel); end
        checks++;
        if (pos !== 4'd0) begin failures++; $display("FAIL repress_pos got=%0d exp=0", pos); end
        cyc(2);
        key_sel_n = 1'b1;
        cyc(8);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_glitch();
        test_sel_hold();
        test_run_pause();
        test_back_to_back();
        test_pause_at_seven();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
